// File: rtl/keytr_multi_pkg.sv
// Shared types for the multi-channel key conditioner: channel state encoding,
// per-channel output payload and the counter sizing helper.
package keytr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        LONG_HELD,
        DEB_RELEASE
    } keystate_t;

    typedef struct packed {
        logic pressed;
        logic press_p;
        logic release_p;
        logic long_p;
        logic repeat_p;
        logic toggled;
    } key_out_t;

    // Wide enough for the largest count any channel counter can hold.
    function automatic int unsigned cnt_width(input int unsigned deb,
                                              input int unsigned lng,
                                              input int unsigned rep);
        int unsigned m;
        m = deb;
        if (lng > m) m = lng;
        if (rep > m) m = rep;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/keytr_multi_if.sv
// Key-side bus of the conditioner: raw keys and toggle clears in, conditioned
// levels and event pulses out.
interface keytr_multi_if #(
    parameter int unsigned N_KEYS = 4
) ();
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] tog_clr;
    logic [N_KEYS-1:0] pressed;
    logic [N_KEYS-1:0] press_p;
    logic [N_KEYS-1:0] release_p;
    logic [N_KEYS-1:0] long_p;
    logic [N_KEYS-1:0] repeat_p;
    logic [N_KEYS-1:0] toggled;

    modport master (
        output key_n, tog_clr,
        input  pressed, press_p, release_p, long_p, repeat_p, toggled
    );

    modport slave (
        input  key_n, tog_clr,
        output pressed, press_p, release_p, long_p, repeat_p, toggled
    );
endinterface

// File: rtl/keytr_multi_key_channel.sv
// One key channel: synchroniser, edge debouncer, long-press / auto-repeat
// timing and toggle latch. All outputs are registered.
module key_channel
    import keytr_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4096,
    parameter int unsigned LONG_CYCLES     = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 250000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     key_n,
    input  logic     tog_clr,
    output key_out_t status
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam bit            DEB_ONE   = (DEBOUNCE_CYCLES == 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("key_channel: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("key_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
        $error("key_channel: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_rep
        $error("key_channel: REPEAT_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    keystate_t     state_q, state_d, ret_q, ret_d, eff_state;
    logic [CW-1:0] deb_q, deb_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] rep_q, rep_d;
    key_out_t      out_q, out_d;

    // Synchroniser resets to the released level.
    always_ff @(posedge clock) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ret_q   <= HELD;
            deb_q   <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ret_d           = ret_q;
        deb_d           = deb_q;
        hold_d          = hold_q;
        rep_d           = rep_q;
        out_d           = out_q;
        out_d.press_p   = 1'b0;
        out_d.release_p = 1'b0;
        out_d.long_p    = 1'b0;
        out_d.repeat_p  = 1'b0;

        // A press seen during release debounce resumes the held state in
        // the same cycle, so its counters advance without losing a cycle.
        eff_state = state_q;
        if (state_q == DEB_RELEASE && !s) eff_state = ret_q;

        case (eff_state)
            IDLE: begin
                if (!s) begin
                    if (DEB_ONE) begin
                        state_d       = HELD;
                        out_d.press_p = 1'b1;
                        out_d.pressed = 1'b1;
                        hold_d        = '0;
                    end else begin
                        state_d = DEB_PRESS;
                        deb_d   = ONE;
                    end
                end
            end
            DEB_PRESS: begin
                if (s) begin
                    state_d = IDLE;
                end else if (deb_q == DEB_LAST) begin
                    state_d       = HELD;
                    out_d.press_p = 1'b1;
                    out_d.pressed = 1'b1;
                    hold_d        = '0;
                end else begin
                    deb_d = deb_q + ONE;
                end
            end
            HELD, LONG_HELD: begin
                if (s) begin
                    ret_d = eff_state;
                    if (DEB_ONE) begin
                        state_d         = IDLE;
                        out_d.release_p = 1'b1;
                        out_d.pressed   = 1'b0;
                    end else begin
                        state_d = DEB_RELEASE;
                        deb_d   = ONE;
                    end
                end else if (eff_state == HELD) begin
                    state_d = HELD;
                    if (hold_q == LONG_LAST) begin
                        state_d      = LONG_HELD;
                        out_d.long_p = 1'b1;
                        rep_d        = '0;
                    end else begin
                        hold_d = hold_q + ONE;
                    end
                end else begin
                    state_d = LONG_HELD;
                    if (rep_q == REP_LAST) begin
                        rep_d          = '0;
                        out_d.repeat_p = REPEAT_EN;
                    end else begin
                        rep_d = rep_q + ONE;
                    end
                end
            end
            DEB_RELEASE: begin
                if (deb_q == DEB_LAST) begin
                    state_d         = IDLE;
                    out_d.release_p = 1'b1;
                    out_d.pressed   = 1'b0;
                end else begin
                    deb_d = deb_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear beats a simultaneous press.
        if (tog_clr) out_d.toggled = 1'b0;
        else         out_d.toggled = out_q.toggled ^ out_d.press_p;
    end

    assign status = out_q;

endmodule

// File: rtl/keytr_multi.sv
// Multi-channel push-button conditioner: N_KEYS independent key channels
// feeding the conditioned key bus.
module keytr_multi
    import keytr_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4096,
    parameter int unsigned LONG_CYCLES     = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 250000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input logic          clock,
    input logic          reset,
    keytr_multi_if.slave keys
);

    if (N_KEYS < 1) begin : g_chk_n
        $error("keytr_multi: N_KEYS must be >= 1");
    end

    key_out_t          ch_out [N_KEYS];
    logic [N_KEYS-1:0] pressed_v, press_v, release_v, long_v, repeat_v, toggled_v;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_EN      (REPEAT_EN)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .key_n  (keys.key_n[i]),
            .tog_clr(keys.tog_clr[i]),
            .status (ch_out[i])
        );
    end

    // Transpose per-channel payloads into per-signal bus vectors.
    always_comb begin
        pressed_v = '0;
        press_v   = '0;
        release_v = '0;
        long_v    = '0;
        repeat_v  = '0;
        toggled_v = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            pressed_v[i] = ch_out[i].pressed;
            press_v[i]   = ch_out[i].press_p;
            release_v[i] = ch_out[i].release_p;
            long_v[i]    = ch_out[i].long_p;
            repeat_v[i]  = ch_out[i].repeat_p;
            toggled_v[i] = ch_out[i].toggled;
        end
    end

    assign keys.pressed   = pressed_v;
    assign keys.press_p   = press_v;
    assign keys.release_p = release_v;
    assign keys.long_p    = long_v;
    assign keys.repeat_p  = repeat_v;
    assign keys.toggled   = toggled_v;

endmodule

// File: tb/tb_keytr_multi.sv
// Self-checking bench for keytr_multi: timing table, directed corner cases
// and randomized key activity against an event-rule reference model.
module tb_keytr_multi;

    localparam int N    = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam bit REN  = 1'b1;

    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

    logic clock = 1'b0;
    logic reset;

    keytr_multi_if #(.N_KEYS(N)) keys ();

    keytr_multi #(
        .N_KEYS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(REN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .keys (keys)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_press0 = 0, n_rel0 = 0, n_rep0 = 0;

    // Reference model: a key is accepted after DEB consecutive agreeing
    // samples; time held (excluding samples that read released) drives
    // long-press and repeat events.
    logic [N-1:0] m_sync [SYNC];
    bit           m_acc [N];
    int           m_run [N];
    int           m_act [N];
    logic [N-1:0] m_pressed, m_press, m_rel, m_long, m_rep, m_tog;

    task automatic model_edge();
        logic [N-1:0] s;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] = '1;
            for (int c = 0; c < N; c++) begin
                m_acc[c] = 0; m_run[c] = 0; m_act[c] = 0;
            end
            m_pressed = '0; m_press = '0; m_rel = '0;
            m_long = '0; m_rep = '0; m_tog = '0;
            return;
        end
        s = m_sync[SYNC-1];
        m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
        for (int c = 0; c < N; c++) begin
            if (!m_acc[c]) begin
                m_run[c] = s[c] ? 0 : m_run[c] + 1;
                if (m_run[c] == DEB) begin
                    m_acc[c] = 1; m_run[c] = 0; m_act[c] = 0; m_press[c] = 1'b1;
                end
            end else if (s[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_acc[c] = 0; m_run[c] = 0; m_rel[c] = 1'b1;
                end
            end else begin
                m_run[c] = 0;
                m_act[c]++;
                if (m_act[c] == LONG) m_long[c] = 1'b1;
                else if (REN && m_act[c] > LONG && (m_act[c] - LONG) % REP == 0) m_rep[c] = 1'b1;
            end
            m_pressed[c] = m_acc[c];
            m_tog[c] = keys.tog_clr[c] ? 1'b0 : (m_tog[c] ^ m_press[c]);
        end
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = keys.key_n;
    endtask

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic run_cycle();
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
        chk("pressed", keys.pressed, m_pressed);
        chk("press_p", keys.press_p, m_press);
        chk("release_p", keys.release_p, m_rel);
        chk("long_p", keys.long_p, m_long);
        chk("repeat_p", keys.repeat_p, m_rep);
        chk("toggled", keys.toggled, m_tog);
        n_press0 += int'(keys.press_p[0]);
        n_rel0   += int'(keys.release_p[0]);
        n_rep0   += int'(keys.repeat_p[0]);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    function automatic logic [N-1:0] get_out(input int kind);
        case (kind)
            K_PRESS: return keys.press_p;
            K_REL:   return keys.release_p;
            K_LONG:  return keys.long_p;
            default: return keys.repeat_p;
        endcase
    endfunction

    task automatic wait_pulse(input int kind, input int ch, input int budget,
                              input string name, output int at);
        logic [N-1:0] v;
        bit done;
        at = -1;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            run_cycle();
            v = get_out(kind);
            if (v[ch]) begin
                at = cyc;
                done = 1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        logic [N-1:0] key_n;
        logic [N-1:0] pressed;
        logic [N-1:0] press_p;
        logic [N-1:0] release_p;
        logic [N-1:0] toggled;
    } vec_t;

    vec_t tab [32];
    int   run_left [N];

    initial begin
        int t0, t1, p, l, r, snap;

        // Table: key 0 driven low for iterations 11..20 (after edge 10).
        for (int i = 0; i < 32; i++) begin
            tab[i].key_n = '1; tab[i].pressed = '0; tab[i].press_p = '0;
            tab[i].release_p = '0; tab[i].toggled = '0;
        end
        for (int i = 11; i <= 20; i++) tab[i].key_n[0] = 1'b0;
        tab[16].press_p[0] = 1'b1;
        for (int i = 16; i <= 25; i++) tab[i].pressed[0] = 1'b1;
        tab[26].release_p[0] = 1'b1;
        for (int i = 16; i < 32; i++) tab[i].toggled[0] = 1'b1;

        reset = 1'b1;
        keys.key_n = '1;
        keys.tog_clr = '0;
        cycles(3);
        chk("reset_pressed", keys.pressed, '0);
        chk("reset_toggled", keys.toggled, '0);
        chk("reset_pulses", keys.press_p | keys.release_p | keys.long_p | keys.repeat_p, '0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            keys.key_n = tab[i].key_n;
            run_cycle();
            chk("tab_pressed", keys.pressed, tab[i].pressed);
            chk("tab_press_p", keys.press_p, tab[i].press_p);
            chk("tab_release_p", keys.release_p, tab[i].release_p);
            chk("tab_toggled", keys.toggled, tab[i].toggled);
        end

        // Bounce: two 3-sample lows never reach acceptance.
        snap = n_press0;
        keys.key_n[0] = 1'b0; cycles(3);
        keys.key_n[0] = 1'b1; cycles(1);
        keys.key_n[0] = 1'b0; cycles(3);
        keys.key_n[0] = 1'b1; cycles(8);
        chk_int("bounce_no_press", n_press0 - snap, 0);
        chk_int("bounce_pressed", int'(keys.pressed[0]), 0);
        keys.key_n[0] = 1'b0; t0 = cyc;
        wait_pulse(K_PRESS, 0, 12, "bounce_press", p);
        chk_int("bounce_press_lat", p - t0, SYNC + DEB);
        cycles(4);
        chk_int("bounce_one_press", n_press0 - snap, 1);
        keys.key_n[0] = 1'b1; t0 = cyc;
        wait_pulse(K_REL, 0, 12, "bounce_release", r);
        chk_int("bounce_release_lat", r - t0, SYNC + DEB);
        cycles(4);

        // Long press and auto-repeat, then release.
        keys.key_n[0] = 1'b0; t0 = cyc;
        wait_pulse(K_PRESS, 0, 12, "lr_press", p);
        chk_int("lr_press_lat", p - t0, 6);
        wait_pulse(K_LONG, 0, 30, "lr_long", l);
        chk_int("lr_long_dt", l - p, 20);
        for (int k = 0; k < 3; k++) begin
            wait_pulse(K_REP, 0, 12, "lr_repeat", r);
            chk_int("lr_repeat_dt", r - p, 28 + 8 * k);
        end
        for (int n = cyc; n < p + 60; n++) run_cycle();
        keys.key_n[0] = 1'b1; t1 = cyc;
        wait_pulse(K_REL, 0, 12, "lr_release", r);
        chk_int("lr_release_lat", r - t1, 6);
        snap = n_rep0;
        cycles(30);
        chk_int("lr_no_repeat", n_rep0 - snap, 0);

        // Two-cycle release glitch while held freezes the hold timer.
        keys.key_n[0] = 1'b0;
        wait_pulse(K_PRESS, 0, 12, "gl_press", p);
        for (int n = cyc; n < p + 5; n++) run_cycle();
        snap = n_rel0;
        keys.key_n[0] = 1'b1; cycles(2);
        keys.key_n[0] = 1'b0;
        wait_pulse(K_LONG, 0, 30, "gl_long", l);
        chk_int("gl_long_dt", l - p, 22);
        chk_int("gl_no_release", n_rel0 - snap, 0);
        chk_int("gl_pressed", int'(keys.pressed[0]), 1);
        keys.key_n[0] = 1'b1;
        wait_pulse(K_REL, 0, 12, "gl_release", r);
        cycles(4);

        // Toggle latch and clear.
        keys.tog_clr[0] = 1'b1; run_cycle(); keys.tog_clr[0] = 1'b0;
        chk_int("tg_cleared", int'(keys.toggled[0]), 0);
        keys.key_n[0] = 1'b0;
        wait_pulse(K_PRESS, 0, 12, "tg_press1", p);
        chk_int("tg_first", int'(keys.toggled[0]), 1);
        keys.key_n[0] = 1'b1;
        wait_pulse(K_REL, 0, 12, "tg_rel1", r);
        keys.key_n[0] = 1'b0;
        wait_pulse(K_PRESS, 0, 12, "tg_press2", p);
        chk_int("tg_second", int'(keys.toggled[0]), 0);
        keys.key_n[0] = 1'b1;
        wait_pulse(K_REL, 0, 12, "tg_rel2", r);
        cycles(2);
        keys.key_n[0] = 1'b0;
        cycles(5);
        keys.tog_clr[0] = 1'b1;
        run_cycle();
        keys.tog_clr[0] = 1'b0;
        chk_int("tg_clr_press_p", int'(keys.press_p[0]), 1);
        chk_int("tg_clr_wins", int'(keys.toggled[0]), 0);

        // Reset while in long hold, key kept low.
        wait_pulse(K_LONG, 0, 30, "rs_long", l);
        cycles(3);
        reset = 1'b1;
        run_cycle();
        chk("rs_pressed", keys.pressed, '0);
        chk("rs_toggled", keys.toggled, '0);
        chk("rs_pulses", keys.press_p | keys.release_p | keys.long_p | keys.repeat_p, '0);
        reset = 1'b0; t0 = cyc;
        wait_pulse(K_PRESS, 0, 12, "rs_press", p);
        chk_int("rs_press_lat", p - t0, SYNC + DEB);
        keys.key_n[0] = 1'b1;
        cycles(12);

        // Randomized activity on all channels.
        for (int c = 0; c < N; c++) run_left[c] = 0;
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < N; c++) begin
                if (run_left[c] == 0) begin
                    keys.key_n[c] = ~keys.key_n[c];
                    run_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 70))
                                                              : int'($urandom_range(1, 8));
                end else begin
                    run_left[c]--;
                end
                keys.tog_clr[c] = ($urandom_range(0, 19) == 0);
            end
            reset = ($urandom_range(0, 599) == 0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keytr_multi.md
Name: keytr_multi

Overview:
Parametrised multi-channel push-button conditioner; successor to the single-key toggle/debounce block.
- Per channel: synchronise an active-low raw key, debounce both edges, and emit level, press/release pulses, long-press pulse, auto-repeat pulses and a toggle latch.
- Sits between board key pins and the effect-control logic: effect select, parameter step up/down, bypass toggles.

Parameters:
N_KEYS, 4, number of independent key channels
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4096, consecutive stable samples required to accept a press or release (>=1)
LONG_CYCLES, 1000000, cycles from press acceptance to long-press event (>DEBOUNCE_CYCLES)
REPEAT_CYCLES, 250000, auto-repeat period after long press (>=1)
REPEAT_EN, 1, 1 = generate repeat pulses, 0 = none

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
key_n  in  N_KEYS  raw asynchronous keys, 0 = pressed
tog_clr  in  N_KEYS  synchronous per-channel toggle clear
pressed  out  N_KEYS  debounced level, 1 = held
press_p  out  N_KEYS  1-cycle pulse on accepted press
release_p  out  N_KEYS  1-cycle pulse on accepted release
long_p  out  N_KEYS  1-cycle pulse when press reaches LONG_CYCLES
repeat_p  out  N_KEYS  1-cycle pulse every REPEAT_CYCLES after long_p
toggled  out  N_KEYS  flips on each press_p

Behaviour:
- Reset: synchroniser flops = 1 (released); all states IDLE; counters 0; every output 0.
- Synchroniser: sample s = key_n after SYNC_STAGES flops. Pressed means s == 0.
- Per-channel FSM, states IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE:
  - IDLE: s==0 -> DEB_PRESS, deb_cnt=1.
  - DEB_PRESS: s==1 -> IDLE, no pulse. s==0: deb_cnt++. On the sample where deb_cnt reaches DEBOUNCE_CYCLES -> HELD; press_p=1, pressed=1, hold_cnt=0.
  - HELD: hold_cnt++. At hold_cnt==LONG_CYCLES-1 -> LONG_HELD; long_p=1, rep_cnt=0.
  - LONG_HELD: rep_cnt++. At REPEAT_CYCLES-1, wrap to 0; repeat_p=1 if REPEAT_EN.
  - HELD or LONG_HELD with s==1: -> DEB_RELEASE, deb_cnt=1. The return state is remembered; hold_cnt and rep_cnt freeze.
  - DEB_RELEASE: s==0 -> back to the remembered state, counters resume, no pulses. Stable s==1 for DEBOUNCE_CYCLES -> IDLE; release_p=1, pressed=0.
- Latency: with key_n held low from posedge k, press_p and pressed assert after posedge k+SYNC_STAGES+DEBOUNCE_CYCLES. Release mirrors this.
- pressed stays 1 through DEB_RELEASE.
- All outputs are registered. Pulses last exactly one cycle. At most one of press_p/release_p/long_p/repeat_p is active per channel per cycle.
- toggled: flips on the press_p cycle. tog_clr forces 0 next cycle and wins over a simultaneous press_p.
- Counters: width = $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)+1), unsigned, no overflow reachable.
- reset mid-operation: returns to the reset state next cycle; no pulses issued.
- Channels are fully independent; simultaneous activity on all channels is legal.
- Elaboration assertions on parameter constraints.

Decomposition:
- keytr_pkg: state enum keystate_t {IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE}; counter-width function.
- Sub-module key_channel: one synchroniser, FSM and counter set. The top level is a generate loop over N_KEYS plus the output bus.

Test Plan:
Params for all scenarios: N_KEYS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
1. Clean press: key_n[0] low from edge 10 -> press_p[0] and pressed[0] at edge 16, toggled[0]=1; key_n[1] outputs stay 0.
2. Bounce: key_n[0] low 3 cycles, high 1, low 3, then high -> no press_p, pressed stays 0; low held 4+ cycles afterwards -> one press_p.
3. Long/repeat: hold key_n[0] 60 cycles after acceptance -> long_p 20 cycles after press_p, repeat_p at +28, +36, +44, ...; release -> release_p 6 cycles after key_n rises, no further repeats.
4. Release glitch: while HELD, 2-cycle high glitch -> no release_p, pressed stays 1, long_p delayed by the 2 frozen cycles.
5. Toggle/clear: two separate presses -> toggled 1 then 0; tog_clr[0] asserted on the press_p cycle -> toggled=0.
6. Reset mid-hold: assert reset while in LONG_HELD -> next cycle all outputs 0, state IDLE; key still low after reset -> fresh press_p after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
